// File: rtl/array.sv
// Flop-based register array: height_p entries of width_p bits.
// One synchronous write port and one combinational read port share index_i.
// Storage clears asynchronously whenever reset_n_i is low. Out-of-range
// indices (non-power-of-two heights) ignore writes and read as zero.
module array #(
    parameter int width_p  = 8,
    parameter int height_p = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        w_v_i,
    input  logic [$clog2(height_p)-1:0] index_i,
    input  logic [width_p-1:0]          data_i,
    output logic [width_p-1:0]          data_o
);

    localparam int idx_w_lp = $clog2(height_p);

    logic [width_p-1:0] r_mem [height_p];
    logic [width_p-1:0] w_rd_data;

    // Storage update: async clear, then a single decoded write per enabled cycle.
    // NOTE: the entries live in flops rather than a RAM macro, so clearing every
    // word in the async reset branch is legal and gives immediate zeros.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < height_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_v_i) begin
            for (int i = 0; i < height_p; i++) begin
                if (index_i == idx_w_lp'(i)) begin
                    r_mem[i] <= data_i;
                end
            end
        end
    end

    // Read mux: a compare per entry, so an index beyond height_p matches nothing.
    // NOTE: the zero default ahead of the loop keeps this purely combinational;
    // without it an unmatched index would leave w_rd_data unassigned (a latch).
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < height_p; i++) begin
            if (index_i == idx_w_lp'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    assign data_o = w_rd_data;

endmodule

// File: tb/tb_array.sv
// Self-checking bench for array: directed vector table, hand-written
// reset/out-of-range sequences, and a random run against a reference model.
module tb_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_v = 1'b0;
    logic [1:0] idx = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;

    logic       w_v3 = 1'b0;
    logic [1:0] idx3 = '0;
    logic [7:0] din3 = '0;
    logic [7:0] dout3;

    int n_cmp = 0;
    int n_bad = 0;

    array #(.width_p(8), .height_p(4)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .w_v_i    (w_v),
        .index_i  (idx),
        .data_i   (din),
        .data_o   (dout)
    );

    array #(.width_p(8), .height_p(3)) dut3 (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .w_v_i    (w_v3),
        .index_i  (idx3),
        .data_i   (din3),
        .data_o   (dout3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [1:0] idx;
        logic [7:0] din;
        logic [7:0] exp;   // data_o expected before the edge
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr4(input logic [1:0] i, input logic [7:0] d);
        w_v = 1'b1; idx = i; din = d;
        @(posedge clk); #1;
        w_v = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] i, input logic [7:0] d);
        w_v3 = 1'b1; idx3 = i; din3 = d;
        @(posedge clk); #1;
        w_v3 = 1'b0;
    endtask

    vec_t       vecs [19];
    logic [7:0] model [4];

    initial begin
        vecs = '{
            '{1'b0, 2'd0, 8'h00, 8'h00},  // reset sweep
            '{1'b0, 2'd1, 8'h00, 8'h00},
            '{1'b0, 2'd2, 8'h00, 8'h00},
            '{1'b0, 2'd3, 8'h00, 8'h00},
            '{1'b1, 2'd2, 8'hA5, 8'h00},  // write/read-back
            '{1'b1, 2'd1, 8'h3C, 8'h00},
            '{1'b0, 2'd2, 8'h00, 8'hA5},
            '{1'b0, 2'd1, 8'h00, 8'h3C},
            '{1'b0, 2'd0, 8'h00, 8'h00},
            '{1'b0, 2'd3, 8'h00, 8'h00},
            '{1'b1, 2'd3, 8'h11, 8'h00},  // read-during-write
            '{1'b1, 2'd3, 8'h22, 8'h11},
            '{1'b0, 2'd3, 8'h00, 8'h22},
            '{1'b1, 2'd0, 8'hFF, 8'h00},  // overwrite and isolation
            '{1'b1, 2'd0, 8'h01, 8'hFF},
            '{1'b0, 2'd0, 8'h00, 8'h01},
            '{1'b0, 2'd1, 8'h00, 8'h3C},
            '{1'b0, 2'd2, 8'h00, 8'hA5},
            '{1'b0, 2'd3, 8'h00, 8'h22}
        };

        // Reset held: all reads zero, write attempt blocked.
        #12;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i); #1;
            check($sformatf("reset_read_%0d", i), dout, 8'h00);
        end
        w_v = 1'b1; idx = 2'd1; din = 8'hAA;
        @(posedge clk); #1;
        check("write_blocked_in_reset", dout, 8'h00);
        w_v = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int k = 0; k < 19; k++) begin
            w_v = vecs[k].wv; idx = vecs[k].idx; din = vecs[k].din;
            @(negedge clk);
            check($sformatf("vec_%0d", k), dout, vecs[k].exp);
            @(posedge clk); #1;
        end
        w_v = 1'b0;

        // Async reset mid-run.
        for (int i = 0; i < 4; i++) wr4(2'(i), 8'(8'h10 + i));
        idx = 2'd2; #1;
        check("filled_idx2", dout, 8'h12);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check("async_clear_immediate", dout, 8'h00);
        w_v = 1'b1; din = 8'h77;
        @(posedge clk); #1;
        check("write_blocked_mid_reset", dout, 8'h00);
        w_v = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i); #1;
            check($sformatf("post_reset_read_%0d", i), dout, 8'h00);
        end
        wr4(2'd1, 8'h5A);
        idx = 2'd1; #1;
        check("first_write_after_release", dout, 8'h5A);

        // Non-power-of-two height: index 3 is out of range.
        wr3(2'd0, 8'h31);
        wr3(2'd1, 8'h32);
        wr3(2'd2, 8'h33);
        wr3(2'd3, 8'hEE);
        for (int i = 0; i < 3; i++) begin
            idx3 = 2'(i); #1;
            check($sformatf("h3_read_%0d", i), dout3, 8'(8'h31 + i));
        end
        idx3 = 2'd3; #1;
        check("h3_out_of_range_read", dout3, 8'h00);

        // Random run against a reference model, starting from a fresh reset.
        @(negedge clk); #2;
        rst_n = 1'b0; #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        @(posedge clk); #1;
        for (int c = 0; c < 10000; c++) begin
            w_v = 1'($urandom_range(0, 1));
            idx = 2'($urandom_range(0, 3));
            din = 8'($urandom);
            @(negedge clk);
            check($sformatf("rand_%0d", c), dout, model[idx]);
            @(posedge clk);
            if (w_v) model[idx] = din;
            #1;
        end
        w_v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/array.md
ARRAY -- requirements
Module: array

Interface
REQ-001 The block SHALL have parameter width_p, default 8, meaning the data word width in bits (minimum 1).
REQ-002 The block SHALL have parameter height_p, default 4, meaning the number of storage entries (minimum 2; need not be a power of two).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock; all writes are on the rising edge.
REQ-005 The block SHALL have port reset_n_i, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port w_v_i, input, 1 bit: write valid.
REQ-007 The block SHALL have port index_i, input, $clog2(height_p) bits: entry address for both read and write.
REQ-008 The block SHALL have port data_i, input, width_p bits: write data.
REQ-009 The block SHALL have port data_o, output, width_p bits: read data.

Function
REQ-010 Storage SHALL be height_p entries of width_p bits, held in flops.
REQ-011 Write: on a rising clk_i with reset_n_i=1 and w_v_i=1, the entry at index_i SHALL take data_i.
REQ-012 With w_v_i=0, no entry SHALL change.
REQ-013 Exactly one entry SHALL be written per write cycle; all other entries hold.
REQ-014 Read SHALL be combinational, with zero latency: data_o = entry[index_i] at all times, independent of w_v_i.
REQ-015 Read-during-write: in the write cycle, data_o SHALL show the old contents of entry[index_i] until the edge. After the edge, data_o SHALL show the written value.
REQ-016 Out-of-range index (index_i >= height_p, non-power-of-two height only): writes SHALL be ignored and data_o SHALL be all zeros.
REQ-017 Back-to-back writes to the same index SHALL leave the last written value. No throttling and no handshake beyond w_v_i apply.

Reset
REQ-018 While reset_n_i=0, all entries SHALL be cleared to 0 immediately (asynchronously), and data_o SHALL read 0 for any in-range index_i.
REQ-019 Writes SHALL be blocked while reset_n_i=0.
REQ-020 Release of reset_n_i SHALL be safe at any time relative to clk_i. The first write SHALL be accepted on the first rising edge with reset_n_i=1.
REQ-021 Reset asserted mid-operation SHALL discard all stored data.

Verification
REQ-022 Reset then read: assert reset_n_i=0, release, sweep index_i 0..3 with w_v_i=0 -> data_o=0x00 for each index.
REQ-023 Write/read-back: write 0xA5 to index 2 and 0x3C to index 1, then read with w_v_i=0 -> index 2 returns 0xA5, index 1 returns 0x3C, and indices 0 and 3 return 0x00.
REQ-024 Read-during-write: entry 3 holds 0x11, then set w_v_i=1, index_i=3, data_i=0x22 -> data_o=0x11 before the edge and 0x22 after the edge.
REQ-025 Overwrite and isolation: write 0xFF to index 0 then 0x01 to index 0 -> index 0 reads 0x01, and the other entries are unchanged.
REQ-026 Random scoreboard: 10k cycles of random index_i, data_i and w_v_i against a reference model -> every read with w_v_i=0 of an entry written at least once matches the model.
REQ-027 Async reset mid-run: fill all entries with nonzero values, pulse reset_n_i low between clock edges -> data_o=0x00 immediately, and all entries read 0x00 afterwards.
